bus_host_arbiter: RTL and testbench

//  Shares one device-side request/response port (e.g. a RAM port) between NrHosts requesters.

---
 rtl/bus_host_arbiter.sv | 173 +++++++++++++++++
 tb/tb_bus_host_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_host_arbiter.sv
// bus_host_arbiter: round-robin arbiter sharing one device request/response port
// between NrHosts requesters. An in-order FIFO of granted host ids routes each
// device response back to the host that issued the matching request.
module bus_host_arbiter #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NrHosts-1:0]                        host_req_i,
  output logic [NrHosts-1:0]                        host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]      host_addr_i,
  input  logic [NrHosts-1:0]                        host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]       host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]         host_wdata_i,
  output logic [NrHosts-1:0]                        host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]         host_rdata_o,
  output logic [NrHosts-1:0]                        host_err_o,
  output logic                                      dev_req_o,
  input  logic                                      dev_gnt_i,
  output logic [AddressWidth-1:0]                   dev_addr_o,
  output logic                                      dev_we_o,
  output logic [DataWidth/8-1:0]                    dev_be_o,
  output logic [DataWidth-1:0]                      dev_wdata_o,
  input  logic                                      dev_rvalid_i,
  input  logic [DataWidth-1:0]                      dev_rdata_i,
  input  logic                                      dev_err_i,
  output logic                                      unexp_rsp_o
);

  localparam int unsigned IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e          state_q;
  logic [IdW-1:0]  rr_ptr_q;
  logic [IdW-1:0]  lock_id_q;
  logic [IdW-1:0]  fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            unexp_q;

  logic [IdW-1:0]  winner;
  logic            winner_found;
  int unsigned     cand;
  logic [IdW-1:0]  sel_id;
  logic            fifo_full;
  logic            fifo_empty;
  logic            accept;
  logic            push;
  logic            pop;
  logic [IdW-1:0]  head_id;

  assign fifo_full  = (count_q == CntW'(MaxOutstanding));
  assign fifo_empty = (count_q == '0);
  assign head_id    = fifo_q[rd_ptr_q];

  // Round-robin pick: first requester at index >= rr_ptr, wrapping.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = 0;
    for (int unsigned i = 0; i < NrHosts; i++) begin
      cand = (32'(rr_ptr_q) + i) % NrHosts;
      if (!winner_found && host_req_i[cand]) begin
        winner_found = 1'b1;
        winner       = IdW'(cand);
      end
    end
  end

  // Request side: pick the active host and drive its fields to the device.
  // dev_req_o is also held low while rst_ni is asserted so nothing is issued
  // during reset even though IDLE would otherwise forward a pending request.
  always_comb begin
    sel_id    = (state_q == LOCKED) ? lock_id_q : winner;
    dev_req_o = 1'b0;
    if (rst_ni) begin
      if (state_q == LOCKED) dev_req_o = host_req_i[lock_id_q];
      else                   dev_req_o = winner_found && !fifo_full;
    end
    dev_addr_o  = host_addr_i[sel_id];
    dev_we_o    = host_we_i[sel_id];
    dev_be_o    = host_be_i[sel_id];
    dev_wdata_o = host_wdata_i[sel_id];
    accept      = dev_req_o && dev_gnt_i;
    push        = accept;
    pop         = dev_rvalid_i && !fifo_empty;
    host_gnt_o  = '0;
    if (accept) host_gnt_o[sel_id] = 1'b1;
  end

  // Response side: route the device response to the FIFO head host only.
  always_comb begin
    host_rvalid_o = '0;
    host_rdata_o  = '0;
    host_err_o    = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (pop && head_id == IdW'(h)) begin
        host_rvalid_o[h] = 1'b1;
        host_rdata_o[h]  = dev_rdata_i;
        host_err_o[h]    = dev_err_i;
      end
    end
  end

  assign unexp_rsp_o = unexp_q;

  // Arbitration FSM, round-robin pointer, FIFO pointers/count and unexpected flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      unexp_q   <= 1'b0;
    end else begin
      unexp_q <= dev_rvalid_i && fifo_empty;

      case (state_q)
        IDLE: begin
          if (dev_req_o && !dev_gnt_i) begin
            state_q   <= LOCKED;
            lock_id_q <= winner;
          end
        end
        LOCKED: begin
          if (!host_req_i[lock_id_q] || dev_gnt_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        rr_ptr_q <= (sel_id == IdW'(NrHosts - 1)) ? '0 : sel_id + 1'b1;
      end

      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Outstanding-id storage; contents are only meaningful while count_q > 0.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= sel_id;
  end

  // The locked host must keep its request up until the device grants it.
  a_no_retract : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (state_q == LOCKED) |-> host_req_i[lock_id_q]
  );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: directed scenarios plus random
// traffic, compared against a queue-based model of the arbitration rules.
module tb_bus_host_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 4;
  localparam int BW = DW / 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N-1:0]            host_req = '0;
  logic [N-1:0]            host_gnt;
  logic [N-1:0][AW-1:0]    host_addr = '0;
  logic [N-1:0]            host_we = '0;
  logic [N-1:0][BW-1:0]    host_be = '0;
  logic [N-1:0][DW-1:0]    host_wdata = '0;
  logic [N-1:0]            host_rvalid;
  logic [N-1:0][DW-1:0]    host_rdata;
  logic [N-1:0]            host_err;
  logic                    dev_req;
  logic                    dev_gnt = 1'b0;
  logic [AW-1:0]           dev_addr;
  logic                    dev_we;
  logic [BW-1:0]           dev_be;
  logic [DW-1:0]           dev_wdata;
  logic                    dev_rvalid = 1'b0;
  logic [DW-1:0]           dev_rdata = '0;
  logic                    dev_err = 1'b0;
  logic                    unexp_rsp;

  always #5 clk = ~clk;

  bus_host_arbiter #(
    .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
    .dev_be_o(dev_be), .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid),
    .dev_rdata_i(dev_rdata), .dev_err_i(dev_err), .unexp_rsp_o(unexp_rsp)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: pointer, lock, outstanding grant order.
  int rr = 0;
  bit locked = 0;
  int lock_id = 0;
  int q[$];
  bit unexp_exp = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rr = 0; locked = 0; lock_id = 0; q.delete(); unexp_exp = 0;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv,
                       input logic [DW-1:0] rd, input logic er);
    host_req = req; dev_gnt = gnt; dev_rvalid = rv; dev_rdata = rd; dev_err = er;
    for (int h = 0; h < N; h++) begin
      host_addr[h]  = $urandom;
      host_we[h]    = 1'($urandom_range(0, 1));
      host_be[h]    = BW'($urandom);
      host_wdata[h] = $urandom;
    end
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic cycle();
    int id;
    bit req_e;
    bit found;
    bit pop;
    int head;
    logic [N-1:0] gnt_e;
    logic [N-1:0] rv_e;
    @(negedge clk);
    id = 0; found = 0;
    if (locked) begin
      id = lock_id;
      req_e = host_req[lock_id];
    end else begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (rr + i) % N;
        if (!found && host_req[c]) begin found = 1; id = c; end
      end
      req_e = found && (q.size() < MO);
    end
    chk("dev_req", 64'(dev_req), 64'(req_e));
    gnt_e = (req_e && dev_gnt) ? (N'(1) << id) : '0;
    chk("host_gnt", 64'(host_gnt), 64'(gnt_e));
    if (req_e) begin
      chk("dev_addr", 64'(dev_addr), 64'(host_addr[id]));
      chk("dev_we", 64'(dev_we), 64'(host_we[id]));
      chk("dev_be", 64'(dev_be), 64'(host_be[id]));
      chk("dev_wdata", 64'(dev_wdata), 64'(host_wdata[id]));
    end
    pop  = dev_rvalid && (q.size() > 0);
    head = pop ? q[0] : 0;
    rv_e = pop ? (N'(1) << head) : '0;
    chk("host_rvalid", 64'(host_rvalid), 64'(rv_e));
    for (int h = 0; h < N; h++) begin
      chk("host_rdata", 64'(host_rdata[h]), rv_e[h] ? 64'(dev_rdata) : 64'd0);
      chk("host_err", 64'(host_err[h]), rv_e[h] ? 64'(dev_err) : 64'd0);
    end
    chk("unexp_rsp", 64'(unexp_rsp), 64'(unexp_exp));
    @(posedge clk);
    #1;
    unexp_exp = dev_rvalid && (q.size() == 0);
    if (pop) void'(q.pop_front());
    if (req_e && dev_gnt) begin
      q.push_back(id);
      rr = (id + 1) % N;
    end
    if (!locked && req_e && !dev_gnt) begin
      locked = 1; lock_id = id;
    end else if (locked && (dev_gnt || !host_req[lock_id])) begin
      locked = 0;
    end
  endtask

  // Empty the outstanding queue; a locked host keeps its request and gets granted.
  task automatic drain();
    for (int k = 0; k < 2 * MO + 2 && (q.size() > 0 || locked); k++) begin
      drive(locked ? (N'(1) << lock_id) : '0, 1'b1, 1'b1, $urandom, 1'b0);
      cycle();
    end
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    cycle();
  endtask

  // Assert reset with traffic still applied; outputs must drop at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_dev_req", 64'(dev_req), 64'd0);
    chk("rst_host_gnt", 64'(host_gnt), 64'd0);
    chk("rst_host_rvalid", 64'(host_rvalid), 64'd0);
    chk("rst_unexp", 64'(unexp_rsp), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_dev_req", 64'(dev_req), 64'd0);
    chk("rst_hold_gnt", 64'(host_gnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    drive('0, 1'b0, 1'b0, '0, 1'b0);
    do_reset();

    // Round robin: both request, device always grants, responses follow.
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0); cycle();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 1'b1, 1'b1, $urandom, 1'b0); cycle();
    end
    drain();

    // Lock: host1 wins, no device grant for 3 cycles, host0 joins meanwhile.
    drive(2'b10, 1'b0, 1'b0, '0, 1'b0); cycle();
    drive(2'b11, 1'b0, 1'b0, '0, 1'b0); cycle();
    drive(2'b11, 1'b0, 1'b0, '0, 1'b0); cycle();
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0); cycle();
    drain();

    // Full FIFO: 4 accepts, 5th request held off, then one response frees a slot.
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, 1'b1, 1'b0, '0, 1'b0); cycle();
    end
    drive(2'b01, 1'b1, 1'b1, 32'h1111_0000, 1'b0); cycle();
    drive(2'b01, 1'b1, 1'b0, '0, 1'b0); cycle();

    // Reset with the FIFO occupied, then a stale response must be flagged.
    drive(2'b11, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    do_reset();
    drive('0, 1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0); cycle();
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0); cycle();
    drain();

    // Routing: grants 0,1,1 then responses A, B (error), C.
    drive(2'b01, 1'b1, 1'b0, '0, 1'b0); cycle();
    drive(2'b10, 1'b1, 1'b0, '0, 1'b0); cycle();
    drive(2'b10, 1'b1, 1'b0, '0, 1'b0); cycle();
    drive('0, 1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0); cycle();
    drive('0, 1'b0, 1'b1, 32'hBBBB_BBBB, 1'b1); cycle();
    drive('0, 1'b0, 1'b1, 32'hCCCC_CCCC, 1'b0); cycle();
    drain();

    // Push+pop with two outstanding, long enough to wrap the FIFO pointers.
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0); cycle();
    drive(2'b11, 1'b1, 1'b0, '0, 1'b0); cycle();
    for (int k = 0; k < 10; k++) begin
      drive(2'b11, 1'b1, 1'b1, $urandom, 1'(k % 3 == 1)); cycle();
    end
    drain();

    // Random traffic; the locked host never retracts its request.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if (locked) r[lock_id] = 1'b1;
      drive(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            $urandom, 1'($urandom_range(0, 7) == 0));
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
